// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response engine: sweeps an N_IN-bit vector in ascending order,
// samples a one-bit response after a settle time and compares the table with an expected one.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [(1<<N_IN)-1:0]   i_expected,
    input  logic                   i_y,
    output logic [N_IN-1:0]        o_vec,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic [(1<<N_IN)-1:0]   o_table_out,
    output logic [(1<<N_IN)-1:0]   o_mismatch
);

    localparam int T = 1 << N_IN;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};
    localparam logic [3:0]      CNT_SETTLE = 4'(SETTLE);

    logic [0:0]      r_state;
    logic [N_IN-1:0] r_vec;
    logic [3:0]      r_cnt;
    logic [T-1:0]    r_exp;
    logic [T-1:0]    r_table;
    logic [T-1:0]    r_mismatch;
    logic            r_pass;
    logic            r_busy;
    logic            r_done;

    logic [T-1:0]    w_table_upd;
    logic            w_settled;
    logic            w_last;

    // Table as it will look once the current response has been written in
    always_comb begin
        w_table_upd        = r_table;
        w_table_upd[r_vec] = i_y;
    end

    // Capture and end-of-sweep qualifiers
    always_comb begin
        w_settled = (r_cnt == CNT_SETTLE);
        w_last    = (r_vec == VEC_LAST);
    end

    // Sweep sequencer; vec only moves on capture edges so the block under test sees clean steps
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_vec      <= '0;
            r_cnt      <= 4'd0;
            r_exp      <= '0;
            r_table    <= '0;
            r_mismatch <= '0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= ST_HOLD;
                        r_exp      <= i_expected;
                        r_vec      <= '0;
                        r_cnt      <= 4'd0;
                        r_table    <= '0;
                        r_mismatch <= '0;
                        r_pass     <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!w_settled) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_table <= w_table_upd;
                        r_cnt   <= 4'd0;
                        if (!w_last) begin
                            r_vec <= r_vec + N_IN'(1);
                        end else begin
                            // Final compare includes the sample taken on this very edge
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_vec      <= '0;
                            r_mismatch <= w_table_upd ^ r_exp;
                            r_pass     <= (w_table_upd == r_exp);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_vec       = r_vec;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_table_out = r_table;
    assign o_mismatch  = r_mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (defaults, and N_IN=2/SETTLE=3) driven by directed
// and random sweeps, checked against a timing/table model derived from the sweep rules.
module tb_truth_table_sweeper;

    logic       clk;
    logic       a_rst_n, a_start, a_y, a_busy, a_done, a_pass;
    logic [7:0] a_exp, a_table, a_mm;
    logic [2:0] a_vec;
    logic       b_rst_n, b_start, b_y, b_busy, b_done, b_pass;
    logic [3:0] b_exp, b_table, b_mm;
    logic [1:0] b_vec;

    int n_checks = 0;
    int n_errors = 0;

    truth_table_sweeper dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_start(a_start), .i_expected(a_exp), .i_y(a_y),
        .o_vec(a_vec), .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
        .o_table_out(a_table), .o_mismatch(a_mm)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_start(b_start), .i_expected(b_exp), .i_y(b_y),
        .o_vec(b_vec), .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
        .o_table_out(b_table), .o_mismatch(b_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic drv_start(input int sel, input logic v);
        if (sel == 1) b_start = v; else a_start = v;
    endtask
    task automatic drv_exp(input int sel, input logic [15:0] v);
        if (sel == 1) b_exp = v[3:0]; else a_exp = v[7:0];
    endtask
    task automatic drv_y(input int sel, input logic v);
        if (sel == 1) b_y = v; else a_y = v;
    endtask
    task automatic drv_rst(input int sel, input logic v);
        if (sel == 1) b_rst_n = v; else a_rst_n = v;
    endtask

    function automatic logic [15:0] get_vec(input int sel);
        return (sel == 1) ? 16'(b_vec) : 16'(a_vec);
    endfunction
    function automatic logic [15:0] get_busy(input int sel);
        return (sel == 1) ? 16'(b_busy) : 16'(a_busy);
    endfunction
    function automatic logic [15:0] get_done(input int sel);
        return (sel == 1) ? 16'(b_done) : 16'(a_done);
    endfunction
    function automatic logic [15:0] get_pass(input int sel);
        return (sel == 1) ? 16'(b_pass) : 16'(a_pass);
    endfunction
    function automatic logic [15:0] get_table(input int sel);
        return (sel == 1) ? 16'(b_table) : 16'(a_table);
    endfunction
    function automatic logic [15:0] get_mm(input int sel);
        return (sel == 1) ? 16'(b_mm) : 16'(a_mm);
    endfunction

    // Truth table of the modelled block y = (a&b)|c, a = vec MSB
    function automatic logic [15:0] tbl_andor();
        logic [15:0] f = 16'h0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v = 3'(i);
            f[i] = (v[2] & v[1]) | v[0];
        end
        return f;
    endfunction

    function automatic logic [15:0] tbl_xor();
        logic [15:0] f = 16'h0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v = 2'(i);
            f[i] = v[1] ^ v[0];
        end
        return f;
    endfunction

    task automatic check_idle_reset(input int sel, input string tag);
        check({tag, "_vec"},   get_vec(sel),   16'h0);
        check({tag, "_busy"},  get_busy(sel),  16'h0);
        check({tag, "_done"},  get_done(sel),  16'h0);
        check({tag, "_pass"},  get_pass(sel),  16'h0);
        check({tag, "_table"}, get_table(sel), 16'h0);
        check({tag, "_mm"},    get_mm(sel),    16'h0);
    endtask

    // One sweep. Called #1 after an edge. y is the true response only in the cycle before each
    // expected capture edge and inverted otherwise, so a mistimed capture shows up in the table.
    // ign_at / rst_at: edge number after E0 at which a stray start / a reset is sampled (-1 = none).
    task automatic run_sweep(input int sel, input logic [15:0] func, input logic [15:0] expv,
                             input int ign_at, input int rst_at, input bit chain);
        int t, s, n;
        logic [15:0] m, ft;
        t  = (sel == 1) ? 4 : 8;
        s  = (sel == 1) ? 3 : 1;
        n  = t * (s + 1);
        m  = 16'((1 << t) - 1);
        ft = func & m;
        drv_exp(sel, expv);
        drv_start(sel, 1'b1);
        @(posedge clk); #1;
        for (int j = 0; j < n; j++) begin
            int k = j / (s + 1);
            check("vec", get_vec(sel), 16'(k));
            check("busy", get_busy(sel), 16'h1);
            check("done_early", get_done(sel), 16'h0);
            if (j == 0) begin
                check("clr_table", get_table(sel), 16'h0);
                check("clr_mm", get_mm(sel), 16'h0);
                check("clr_pass", get_pass(sel), 16'h0);
            end
            drv_start(sel, 1'b0);
            if (j == ign_at - 1) begin
                drv_start(sel, 1'b1);
                drv_exp(sel, 16'h0);
            end
            drv_y(sel, (j % (s + 1) == s) ? ft[k] : ~ft[k]);
            if (j == rst_at - 1) drv_rst(sel, 1'b0);
            @(posedge clk); #1;
            if (j == rst_at - 1) begin
                drv_rst(sel, 1'b1);
                drv_start(sel, 1'b0);
                check_idle_reset(sel, "abort");
                for (int w = 0; w < n + 2; w++) begin
                    check("abort_no_done", get_done(sel), 16'h0);
                    @(posedge clk); #1;
                end
                return;
            end
        end
        drv_start(sel, 1'b0);
        check("done", get_done(sel), 16'h1);
        check("busy_end", get_busy(sel), 16'h0);
        check("vec_end", get_vec(sel), 16'h0);
        check("table", get_table(sel), ft);
        check("mismatch", get_mm(sel), (func ^ expv) & m);
        check("pass", get_pass(sel), 16'(ft == (expv & m)));
        if (!chain) begin
            @(posedge clk); #1;
            check("done_pulse", get_done(sel), 16'h0);
            check("table_hold", get_table(sel), ft);
            check("pass_hold", get_pass(sel), 16'(ft == (expv & m)));
        end
    endtask

    initial begin
        int sel, t;
        logic [15:0] f, e;
        a_rst_n = 1'b0; a_start = 1'b0; a_exp = 8'h00; a_y = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0; b_exp = 4'h0; b_y = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_reset(0, "rst_a");
        check_idle_reset(1, "rst_b");
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(0, tbl_andor(), 16'hEA, -1, -1, 1'b0);
        run_sweep(0, tbl_andor(), 16'hE8, -1, -1, 1'b0);
        run_sweep(0, tbl_andor(), 16'hEA,  5, -1, 1'b0);
        run_sweep(0, tbl_andor(), 16'hEA, -1,  9, 1'b0);
        run_sweep(0, tbl_andor(), 16'hEA, -1, -1, 1'b0);
        run_sweep(1, tbl_xor(),   16'h6,  -1, -1, 1'b0);
        run_sweep(0, tbl_andor(), 16'hEA, -1, -1, 1'b1);
        run_sweep(0, tbl_andor(), 16'hE8, -1, -1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            sel = int'($urandom_range(0, 1));
            t   = (sel == 1) ? 4 : 8;
            f   = 16'($urandom);
            e   = f;
            if ($urandom_range(0, 1) == 1) e = f ^ (16'h1 << $urandom_range(0, t - 1));
            run_sweep(sel, f, e, -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-contained stimulus-and-response engine for small combinational blocks. On a start pulse it drives every input combination onto an N-bit vector in ascending binary order. After a programmable settle time it samples the block's single-bit response for each combination and assembles the measured truth table. It then compares that table against an expected table, reports pass/fail, and reports a per-entry mismatch mask. It sits between on-chip control logic and any 1–4-input boolean block under test, as the hardware counterpart to a software exhaustive-stimulus bench.

## Interface
- N_IN, 3, number of inputs driven (legal 1..4); table width T = 2**N_IN
- SETTLE, 1, cycles each vector is held before the response is sampled (legal 1..15)
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin a sweep; honoured only when idle
- expected  input  T  expected truth table; bit i = expected y for vec == i; latched on accepted start
- y  input  1  response of block under test
- vec  output  N_IN  drive vector to block under test; MSB is the first operand (a), LSB the last (c)
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  measured table == latched expected; valid from done, held until next accepted start
- table_out  output  T  measured truth table, bit i = y sampled for vec == i
- mismatch  output  T  table_out ^ latched expected; valid and held like pass

## Operation
- Reset (rst_n low at an edge): vec=0, busy=0, done=0, pass=0, table_out=0, mismatch=0, settle counter=0, state IDLE.
- States: IDLE, HOLD.
- IDLE → HOLD: start=1 at an edge.
  - Latch expected; vec<=0; counter<=0; table_out<=0; mismatch<=0; pass<=0; busy<=1.
- IDLE with start=0: all outputs hold; done<=0.
- HOLD, counter < SETTLE: counter++.
- HOLD, counter == SETTLE:
  - table_out[vec] <= y, using y as sampled at this edge.
  - If vec < T-1: vec++ and counter<=0.
  - If vec == T-1: state<=IDLE; busy<=0; done<=1; vec<=0; pass and mismatch are computed from the final table including the current sample.
- start while busy is ignored; the sweep is neither restarted nor extended, and expected is not re-latched.
- start in the cycle done is high: accepted, because the state is already IDLE.
- Reset mid-sweep: immediate abort to reset values. No done pulse; partial table discarded.
- Comparison is bitwise over all T bits; unused upper bits do not exist (table width is exactly T).

## Timing
- Each vector is held for SETTLE+1 cycles.
- Let E0 be the edge where start is accepted.
  - Capture for index k occurs at edge E0 + (k+1)(SETTLE+1).
  - done is high in the cycle after edge E0 + T(SETTLE+1).
  - Defaults (N_IN=3, SETTLE=1): done rises 16 edges after E0.
- done is a single-cycle pulse; pass, mismatch and table_out remain stable until the next accepted start.
- vec changes only on capture edges, which makes it glitch-free for the block under test.
- busy falls on the same edge done rises.

## Test plan
- Defaults; the bench models y = (a&b)|c from vec; expected=8'hEA; pulse start.
  - vec steps 0..7, each value held 2 cycles.
  - done is high exactly 16 edges after start.
  - table_out=8'hEA, mismatch=8'h00, pass=1.
- Same model, expected=8'hE8 → table_out=8'hEA, mismatch=8'h02, pass=0.
- Start a sweep; assert start again at edge 5 while changing expected to 8'h00.
  - The second start is ignored; done still at edge 16.
  - Comparison uses the first expected value (8'hEA), so pass=1.
- Assert rst_n=0 for one edge at edge 9 mid-sweep → next cycle vec=0, busy=0, table_out=0, pass=0, and no done pulse. A fresh start then completes normally.
- N_IN=2, SETTLE=3, model y = a^b, expected=4'h6 → each vec held 4 cycles, done at edge 16, table_out=4'h6, pass=1.
- Back-to-back: assert start in the done cycle → new sweep accepted immediately. busy re-rises on the next edge and outputs are cleared; the second done arrives 16 edges later.
